// File: rtl/usb_fs_rx_decoder.sv
// usb_fs_rx_decoder
//
// Full-speed USB receive front end. Synchronises the raw D+/D- pads into the
// 48 MHz domain, recovers bit timing from the 4x oversampled line with a small
// DPLL, detects SYNC, NRZI-decodes, removes stuffed bits and assembles
// LSB-first bytes. Emits one-cycle packet start / byte / end / error strobes.
// No PID or CRC checking is done here.
//
// Optional feature macro: USB_RX_SE0_RESET_DET_EN
//   When defined, a long SE0 (RESET_CYCLES clocks) pulses usb_bus_reset and
//   forces the receiver to IDLE. When undefined, usb_bus_reset is tied low.
//
// Ports:
//   clk_48mhz      sole clock, 4x the 12 Mb/s bit rate
//   reset_n        asynchronous active-low reset
//   usb_p_rx       raw D+ pad input (asynchronous)
//   usb_n_rx       raw D- pad input (asynchronous)
//   usb_tx_en      high while the device transmits; receiver held in IDLE
//   rx_pkt_start   pulse when a valid SYNC completes
//   rx_data        last assembled byte, held between strobes
//   rx_data_valid  pulse when rx_data is updated
//   rx_pkt_end     pulse on a valid EOP
//   rx_err         pulse on a stuff error or non-byte-aligned EOP
//   usb_bus_reset  pulse after a long SE0 (0 without the macro)

module usb_fs_rx_decoder
`ifdef USB_RX_SE0_RESET_DET_EN
#(
    parameter int RESET_CYCLES = 120
)
`endif
(
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       usb_tx_en,
    output logic       rx_pkt_start,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_pkt_end,
    output logic       rx_err,
    output logic       usb_bus_reset
);

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } state_t;

    // Two-stage synchronisers; bit [1] is the stable copy. Reset to the idle
    // J pattern so the line does not look like SE0 right after reset.
    logic [1:0] p_sync;
    logic [1:0] n_sync;

    line_t  line_next;
    line_t  line_state;
    line_t  line_prev;
    logic [1:0] phase;
    logic [1:0] phase_now;
    logic       sample;
    logic       se0_reset_hit;

    state_t     state;
    logic       armed;
    logic [2:0] sync_cnt;
    line_t      sync_expect;
    line_t      prev_level;
    logic [2:0] ones_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       j_seen;
    logic       data_bit;

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            p_sync <= 2'b11;
            n_sync <= 2'b00;
        end else begin
            p_sync <= {p_sync[0], usb_p_rx};
            n_sync <= {n_sync[0], usb_n_rx};
        end
    end

    // SE1 is folded into SE0.
    always_comb begin
        line_next = LS_SE0;
        if (p_sync[1] && !n_sync[1]) begin
            line_next = LS_J;
        end else if (!p_sync[1] && n_sync[1]) begin
            line_next = LS_K;
        end
    end

    // phase_now is the DPLL count for the current cycle: zero on the cycle a
    // line change is visible, so sampling at 2 lands mid-bit for 3..5 clock
    // bit periods.
    assign phase_now = (line_state != line_prev) ? 2'd0 : phase + 2'd1;
    assign sample    = (phase_now == 2'd2);

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            line_state <= LS_J;
            line_prev  <= LS_J;
            phase      <= 2'd0;
        end else begin
            line_state <= line_next;
            line_prev  <= line_state;
            phase      <= phase_now;
        end
    end

`ifdef USB_RX_SE0_RESET_DET_EN
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    logic [CNT_W-1:0] se0_cnt;
    logic             bus_reset_q;

    // Fires exactly once, on the cycle the saturating counter reaches the limit.
    assign se0_reset_hit = (line_state == LS_SE0) &&
                           (se0_cnt == CNT_W'(RESET_CYCLES - 1));

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            se0_cnt     <= '0;
            bus_reset_q <= 1'b0;
        end else begin
            bus_reset_q <= se0_reset_hit;
            if (line_state != LS_SE0) begin
                se0_cnt <= '0;
            end else if (se0_cnt != CNT_W'(RESET_CYCLES)) begin
                se0_cnt <= se0_cnt + 1'b1;
            end
        end
    end

    assign usb_bus_reset = bus_reset_q;
`else
    assign se0_reset_hit = 1'b0;
    assign usb_bus_reset = 1'b0;
`endif

    // SYNC is K J K J K J K K: K on even positions and on the final one.
    assign sync_expect = (!sync_cnt[0] || (sync_cnt == 3'd7)) ? LS_K : LS_J;

    // NRZI: no change from the previous sample decodes to 1.
    assign data_bit = (line_state == prev_level);

    // Receiver FSM with registered strobes. 'armed' records that J has been
    // seen in IDLE, so a K only starts SYNC after a proper idle period.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            armed         <= 1'b0;
            sync_cnt      <= 3'd0;
            prev_level    <= LS_J;
            ones_cnt      <= 3'd0;
            bit_cnt       <= 3'd0;
            shift         <= 7'd0;
            j_seen        <= 1'b0;
            rx_pkt_start  <= 1'b0;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            rx_pkt_end    <= 1'b0;
            rx_err        <= 1'b0;
        end else begin
            rx_pkt_start  <= 1'b0;
            rx_data_valid <= 1'b0;
            rx_pkt_end    <= 1'b0;
            rx_err        <= 1'b0;

            if (usb_tx_en || se0_reset_hit) begin
                state <= ST_IDLE;
                armed <= 1'b0;
            end else if (sample) begin
                case (state)
                    ST_IDLE: begin
                        if (line_state == LS_J) begin
                            armed <= 1'b1;
                        end else if ((line_state == LS_K) && armed) begin
                            state    <= ST_SYNC;
                            sync_cnt <= 3'd1;
                        end else begin
                            armed <= 1'b0;
                        end
                    end

                    ST_SYNC: begin
                        if (line_state != sync_expect) begin
                            state  <= ST_ABORT;
                            j_seen <= 1'b0;
                        end else if (sync_cnt == 3'd7) begin
                            // The final K of SYNC is a decoded 1 and starts the
                            // consecutive-ones run used for unstuffing.
                            state        <= ST_DATA;
                            rx_pkt_start <= 1'b1;
                            prev_level   <= LS_K;
                            ones_cnt     <= 3'd1;
                            bit_cnt      <= 3'd0;
                        end else begin
                            sync_cnt <= sync_cnt + 3'd1;
                        end
                    end

                    ST_DATA: begin
                        if (line_state == LS_SE0) begin
                            state <= ST_EOP;
                        end else begin
                            prev_level <= line_state;
                            if (ones_cnt == 3'd6) begin
                                // This bit must be a stuffed 0; it is dropped.
                                if (data_bit) begin
                                    rx_err <= 1'b1;
                                    state  <= ST_ABORT;
                                    j_seen <= 1'b0;
                                end else begin
                                    ones_cnt <= 3'd0;
                                end
                            end else begin
                                shift    <= {data_bit, shift[6:1]};
                                bit_cnt  <= bit_cnt + 3'd1;
                                ones_cnt <= data_bit ? (ones_cnt + 3'd1) : 3'd0;
                                if (bit_cnt == 3'd7) begin
                                    rx_data       <= {data_bit, shift};
                                    rx_data_valid <= 1'b1;
                                end
                            end
                        end
                    end

                    ST_EOP: begin
                        if (line_state == LS_J) begin
                            rx_pkt_end <= 1'b1;
                            rx_err     <= (bit_cnt != 3'd0);
                            state      <= ST_IDLE;
                            armed      <= 1'b1;
                        end else if (line_state == LS_K) begin
                            rx_err <= 1'b1;
                            state  <= ST_ABORT;
                            j_seen <= 1'b0;
                        end
                    end

                    ST_ABORT: begin
                        if (line_state == LS_J) begin
                            if (j_seen) begin
                                state <= ST_IDLE;
                                armed <= 1'b1;
                            end
                            j_seen <= 1'b1;
                        end else begin
                            j_seen <= 1'b0;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
